sb_master_port: RTL and testbench

//  Bus-master front end that drives the SB slave port (sel/addr/write/trans/size/burst/wdata/master).

---
 rtl/sb_master_port.sv | 181 ++++++++++++++++++
 tb/tb_sb_master_port.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_master_port.sv
// SB bus master front end: one burst command at a time, with SPLIT resume and ERROR abort.
// Optional watchdog and bus lock are enabled by defining SB_MASTER_TIMEOUT_EN.
module sb_master_port #(
  parameter int SB_ADDR_WIDTH  = 32,
  parameter int SB_DATA_WIDTH  = 32,
  parameter int MASTER_ID      = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     sb_clk,
  input  logic                     sb_reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [SB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [4:0]               cmd_len,
  input  logic                     wr_valid,
  input  logic [SB_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_ready,
  output logic                     rd_valid,
  output logic [SB_DATA_WIDTH-1:0] rd_data,
  output logic                     done,
  output logic                     done_err,
  output logic                     sb_sel,
  output logic [SB_ADDR_WIDTH-1:0] sb_addr,
  output logic                     sb_write,
  output logic [1:0]               sb_trans,
  output logic [2:0]               sb_size,
  output logic [2:0]               sb_burst,
  output logic [SB_DATA_WIDTH-1:0] sb_wdata,
  output logic                     sb_master,
  output logic                     sb_mastlock,
  input  logic                     sb_ready,
  input  logic [1:0]               sb_resp,
  input  logic [SB_DATA_WIDTH-1:0] sb_rdata,
  input  logic [1:0]               sb_split
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_SPLIT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [1:0] RSP_OKAY  = 2'd1;
  localparam logic [1:0] RSP_ERROR = 2'd2;
  localparam logic [1:0] RSP_SPLIT = 2'd3;

  localparam logic MID = MASTER_ID[0];

`ifdef SB_MASTER_TIMEOUT_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  function automatic logic len_legal(input logic [4:0] len);
    case (len)
      5'd1, 5'd2, 5'd3, 5'd8, 5'd16: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] size_code(input logic [4:0] len);
    case (len)
      5'd1:    return 3'b010;
      5'd2:    return 3'b011;
      5'd3:    return 3'b100;
      5'd8:    return 3'b101;
      5'd16:   return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  logic [2:0]               state, state_n;
  logic                     write_q;
  logic [SB_ADDR_WIDTH-1:0] base_q;
  logic [4:0]               len_q;
  logic [4:0]               beats_q;
  logic                     err_q;
  logic                     rd_vld_p1;
  logic [SB_DATA_WIDTH-1:0] rd_data_p1;
  logic [6:0]               wd_cnt;

  logic in_data, on_bus, busy, beat, last_beat, split_rel, wd_run, timeout, accept;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign in_data   = (state == S_DATA);
  assign on_bus    = (state == S_ADDR) || in_data;
  assign busy      = in_data && write_q && !wr_valid;
  assign beat      = in_data && sb_ready && (sb_resp == RSP_OKAY) && !busy;
  assign last_beat = beat && (beats_q == len_q - 5'd1);
  assign split_rel = |(sb_split & (2'b01 << MID));

  // Watchdog: counts stalled DATA cycles and SPLIT_WAIT cycles; compiled away when disabled.
  assign wd_run  = (in_data && !sb_ready) || (state == S_SPLIT);
  assign timeout = WD_EN && wd_run && (wd_cnt == 7'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_n = len_legal(cmd_len) ? S_ADDR : S_DONE;
      S_ADDR:  state_n = S_DATA;
      S_DATA: begin
        if (sb_resp == RSP_ERROR || timeout) state_n = S_DONE;
        else if (sb_resp == RSP_SPLIT)       state_n = S_SPLIT;
        else if (last_beat)                  state_n = S_DONE;
      end
      S_SPLIT: begin
        if (timeout)        state_n = S_DONE;
        else if (split_rel) state_n = S_ADDR;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sb_clk) begin
    if (sb_reset) begin
      state     <= S_IDLE;
      beats_q   <= 5'd0;
      err_q     <= 1'b0;
      rd_vld_p1 <= 1'b0;
      wd_cnt    <= 7'd0;
    end else begin
      state     <= state_n;
      rd_vld_p1 <= beat && !write_q;
      if (accept)    beats_q <= 5'd0;
      else if (beat) beats_q <= beats_q + 5'd1;
      if (state == S_IDLE)
        err_q <= cmd_valid && !len_legal(cmd_len);
      else if ((in_data && sb_resp == RSP_ERROR) || timeout)
        err_q <= 1'b1;
      if (beat || state_n != state) wd_cnt <= 7'd0;
      else if (wd_run)              wd_cnt <= wd_cnt + 7'd1;
    end
  end

  // Command fields and read data capture carry no reset.
  always_ff @(posedge sb_clk) begin
    if (accept) begin
      write_q <= cmd_write;
      base_q  <= cmd_addr;
      len_q   <= cmd_len;
    end
    if (beat) rd_data_p1 <= sb_rdata;
  end

  assign cmd_ready = (state == S_IDLE);
  assign wr_ready  = beat && write_q;
  assign rd_valid  = rd_vld_p1;
  assign rd_data   = rd_data_p1;
  assign done      = (state == S_DONE);
  assign done_err  = done && err_q;

  assign sb_sel    = on_bus;
  assign sb_write  = on_bus && write_q;
  assign sb_addr   = on_bus ? base_q + SB_ADDR_WIDTH'(beats_q) : '0;
  assign sb_size   = on_bus ? size_code(len_q) : 3'b000;
  assign sb_burst  = (on_bus && len_q != 5'd1) ? 3'b001 : 3'b000;
  assign sb_wdata  = (in_data && write_q) ? wr_data : '0;
  assign sb_master = MID;

  always_comb begin
    sb_trans = TR_IDLE;
    if (state == S_ADDR) sb_trans = TR_NONSEQ;
    else if (in_data)    sb_trans = busy ? TR_BUSY : TR_SEQ;
  end

`ifdef SB_MASTER_TIMEOUT_EN
  // Lock spans the whole bus transaction, across SPLIT; illegal-length commands never lock.
  assign sb_mastlock = on_bus || (state == S_SPLIT) || (done && len_legal(len_q));
`else
  assign sb_mastlock = 1'b0;
`endif

endmodule

// File: tb/tb_sb_master_port.sv
// Directed bench for sb_master_port: write/read bursts, SPLIT resume, ERROR abort, illegal length,
// reset mid-burst, and (with SB_MASTER_TIMEOUT_EN) the watchdog.
module tb_sb_master_port;

  logic        sb_clk = 1'b0;
  logic        sb_reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic        sb_sel, sb_write, sb_master, sb_mastlock;
  logic [31:0] sb_addr, sb_wdata, sb_rdata;
  logic [1:0]  sb_trans, sb_resp, sb_split;
  logic [2:0]  sb_size, sb_burst;
  logic        sb_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int rdv, wrc;

  sb_master_port #(.SB_ADDR_WIDTH(32), .SB_DATA_WIDTH(32), .MASTER_ID(0), .TIMEOUT_CYCLES(64)) dut (
    .sb_clk(sb_clk), .sb_reset(sb_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err),
    .sb_sel(sb_sel), .sb_addr(sb_addr), .sb_write(sb_write), .sb_trans(sb_trans),
    .sb_size(sb_size), .sb_burst(sb_burst), .sb_wdata(sb_wdata), .sb_master(sb_master),
    .sb_mastlock(sb_mastlock), .sb_ready(sb_ready), .sb_resp(sb_resp),
    .sb_rdata(sb_rdata), .sb_split(sb_split)
  );

  always #5 sb_clk = ~sb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge sb_clk);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [4:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    sb_reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 5'd0;
    wr_valid = 1'b0; wr_data = '0; sb_ready = 1'b1; sb_resp = 2'd1; sb_rdata = '0; sb_split = 2'b00;
    tick(); tick();
    sb_reset = 1'b0;

    // Reset state
    mid();
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst sb_sel", sb_sel, 0);
    chk("rst sb_trans", sb_trans, 0);
    chk("rst sb_addr", sb_addr, 0);
    chk("rst outputs", {wr_ready, rd_valid, done, done_err, sb_mastlock, sb_write, sb_master}, 0);
    chk("rst size/burst", {sb_size, sb_burst}, 0);

    // Write len1 at 0x10
    tick();
    wr_valid = 1'b1; wr_data = 32'hA5A5_A5A5;
    issue(1'b1, 32'h10, 5'd1);
    mid();
    chk("w1 addr-phase sel/trans", {sb_sel, sb_write, sb_trans}, {1'b1, 1'b1, 2'd2});
    chk("w1 addr", sb_addr, 32'h10);
    chk("w1 size/burst", {sb_size, sb_burst}, {3'b010, 3'b000});
    chk("w1 cmd_ready busy", cmd_ready, 0);
    tick();
    mid();
    chk("w1 trans seq", sb_trans, 2'd3);
    chk("w1 wdata", sb_wdata, 32'hA5A5_A5A5);
    chk("w1 wr_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    mid();
    chk("w1 done", {done, done_err, sb_sel}, {1'b1, 1'b0, 1'b0});
    tick();
    mid();
    chk("w1 back idle", {done, cmd_ready}, {1'b0, 1'b1});

    // Read len8 at 0x40
    tick();
    issue(1'b0, 32'h40, 5'd8);
    mid();
    chk("r8 addr", sb_addr, 32'h40);
    chk("r8 size/burst/write", {sb_size, sb_burst, sb_write}, {3'b101, 3'b001, 1'b0});
    tick();
    rdv = 0;
    for (int i = 0; i < 8; i++) begin
      sb_rdata = 32'h1000 + i;
      mid();
      if (rd_valid) rdv++;
      chk("r8 beat addr", sb_addr, 32'h40 + i);
      if (i == 3) begin
        chk("r8 beat rd_data", rd_data, 32'h1002);
        chk("r8 trans", sb_trans, 2'd3);
      end
      tick();
    end
    mid();
    if (rd_valid) rdv++;
    chk("r8 done", {done, done_err}, 2'b10);
    chk("r8 last rd_data", rd_data, 32'h1007);
    tick();
    mid();
    if (rd_valid) rdv++;
    chk("r8 rd_valid count", rdv, 8);

    // Write len16 at 0x100; SPLIT at beat 2 with a same-cycle release, released again later
    tick();
    wr_valid = 1'b1; wr_data = 32'hD000;
    issue(1'b1, 32'h100, 5'd16);
    mid();
    chk("w16 addr/size", {sb_addr[15:0], sb_size, sb_burst}, {16'h0100, 3'b110, 3'b001});
`ifdef SB_MASTER_TIMEOUT_EN
    chk("w16 mastlock", sb_mastlock, 1);
`else
    chk("w16 mastlock", sb_mastlock, 0);
`endif
    tick();
    wrc = 0;
    for (int b = 0; b < 2; b++) begin
      wr_data = 32'hD000 + b;
      mid();
      if (wr_ready) wrc++;
      chk("w16 pre-split addr", sb_addr, 32'h100 + b);
      tick();
    end
    wr_data = 32'hD002; sb_resp = 2'd3; sb_split = 2'b01;
    mid();
    chk("w16 split no beat", wr_ready, 0);
    tick();
    sb_resp = 2'd1; sb_split = 2'b00;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("w16 split wait", {sb_sel, sb_trans, done}, {1'b0, 2'd0, 1'b0});
      tick();
    end
    sb_split = 2'b01;
    mid();
    chk("w16 split wait last", sb_sel, 0);
`ifdef SB_MASTER_TIMEOUT_EN
    chk("w16 lock in split", sb_mastlock, 1);
`endif
    tick();
    sb_split = 2'b00;
    mid();
    chk("w16 reissue", {sb_trans, sb_addr}, {2'd2, 32'h102});
    chk("w16 reissue size", sb_size, 3'b110);
    tick();
    for (int b = 2; b < 16; b++) begin
      if (b == 5) begin
        wr_valid = 1'b0;
        mid();
        chk("w16 busy", {sb_trans, wr_ready}, {2'd1, 1'b0});
        chk("w16 busy addr", sb_addr, 32'h105);
        tick();
        wr_valid = 1'b1;
      end
      wr_data = 32'hD000 + b;
      mid();
      if (wr_ready) wrc++;
      chk("w16 beat addr", sb_addr, 32'h100 + b);
      if (b == 9) chk("w16 wdata", sb_wdata, 32'hD009);
      tick();
    end
    wr_valid = 1'b0;
    mid();
    chk("w16 done", {done, done_err}, 2'b10);
    chk("w16 wr_ready count", wrc, 16);
    tick();

    // Read len3 at 0x200 with ERROR on beat 1
    issue(1'b0, 32'h200, 5'd3);
    mid();
    chk("r3 addr/size", {sb_addr[15:0], sb_size}, {16'h0200, 3'b100});
    tick();
    sb_rdata = 32'hBEEF_0000;
    mid();
    tick();
    sb_resp = 2'd2; sb_rdata = 32'hDEAD_DEAD;
    mid();
    chk("r3 beat0 data", {rd_valid, rd_data}, {1'b1, 32'hBEEF_0000});
    tick();
    sb_resp = 2'd1;
    mid();
    chk("r3 error done", {done, done_err, sb_sel, rd_valid}, 4'b1100);
    tick();
    mid();
    chk("r3 idle", {cmd_ready, done}, 2'b10);

    // Illegal length 5
    issue(1'b1, 32'h300, 5'd5);
    mid();
    chk("len5 done_err", {done, done_err, sb_sel, sb_mastlock}, 4'b1100);
    tick();
    mid();
    chk("len5 after", {done, cmd_ready}, 2'b01);

    // Reset mid-burst, then a fresh len2 read
    issue(1'b0, 32'h300, 5'd8);
    tick(); tick(); tick();
    sb_reset = 1'b1;
    tick();
    sb_reset = 1'b0;
    mid();
    chk("midrst state", {sb_sel, cmd_ready, done, rd_valid}, 4'b0100);
    tick();
    mid();
    chk("midrst no done", done, 0);
    issue(1'b0, 32'h20, 5'd2);
    mid();
    chk("r2 addr/size", {sb_addr[7:0], sb_size, sb_burst}, {8'h20, 3'b011, 3'b001});
    tick();
    sb_rdata = 32'h55;
    mid();
    chk("r2 beat0 addr", sb_addr, 32'h20);
    tick();
    sb_rdata = 32'h66;
    mid();
    chk("r2 beat1 addr", sb_addr, 32'h21);
    tick();
    mid();
    chk("r2 done", {done, done_err, rd_valid, rd_data}, {3'b101, 32'h66});
    tick();

`ifdef SB_MASTER_TIMEOUT_EN
    // Watchdog: slave never ready
    sb_ready = 1'b0;
    issue(1'b0, 32'h50, 5'd1);
    tick();
    for (int k = 1; k < 64; k++) tick();
    mid();
    chk("wd before limit", {sb_sel, done}, 2'b10);
    tick();
    mid();
    chk("wd timeout", {done, done_err, sb_mastlock}, 3'b111);
    tick();
    sb_ready = 1'b1;
    mid();
    chk("wd idle", cmd_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
